// File: rtl/reg_file_sb.sv
// Register file with per-register pending (scoreboard) bits and writeback bypass.
// Latency: reads and hazard flags are combinational; writes/issues land on the next clk edge.
// Backpressure: none; iss_busy/rd_busy only report hazards, and every strobe is accepted.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_busy,
  output logic [AW:0]          pend_cnt
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_pend_cnt;

  // Strobes aimed at x0 are dropped here, so x0 can never hold data or go busy.
  logic w_wr_hit;
  logic w_iss_hit;
  logic w_inc;
  logic w_dec;

  assign w_wr_hit  = wr_en  && (wr_addr  != '0);
  assign w_iss_hit = iss_en && (iss_addr != '0);

  // Count moves only when a busy bit actually changes; a write that is re-issued
  // in the same cycle leaves its bit set, so it does not decrement.
  assign w_inc = w_iss_hit && !r_busy[iss_addr];
  assign w_dec = w_wr_hit && r_busy[wr_addr] && !(w_iss_hit && (iss_addr == wr_addr));

  assign iss_busy = r_busy[iss_addr];
  assign pend_cnt = r_pend_cnt;

  // Architectural data: cleared on reset, written on writeback to a nonzero address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_hit) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Pending bits: writeback clears, issue sets; the later assignment makes issue win on a tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      if (w_wr_hit) begin
        r_busy[wr_addr] <= 1'b0;
      end
      if (w_iss_hit) begin
        r_busy[iss_addr] <= 1'b1;
      end
    end
  end

  // Pending count tracks popcount(r_busy) incrementally; simultaneous +1/-1 cancel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_cnt <= '0;
    end else if (w_inc && !w_dec) begin
      r_pend_cnt <= r_pend_cnt + (AW+1)'(1);
    end else if (w_dec && !w_inc) begin
      r_pend_cnt <= r_pend_cnt - (AW+1)'(1);
    end
  end

  // Read ports: direct array lookup, optionally overridden by the in-flight writeback.
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_fwd;

    assign w_ra  = rd_addr[g*AW +: AW];
    assign w_fwd = (BYPASS != 0) && w_wr_hit && (wr_addr == w_ra);

    assign rd_data[g*XLEN +: XLEN] = w_fwd ? wr_data : r_regs[w_ra];
    assign rd_busy[g]              = w_fwd ? 1'b0    : r_busy[w_ra];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (bypass on/off) share stimulus.
// Expected values come from an array model of registers and busy bits.
// Directed scenarios first, then randomized cycles checked every cycle.
module tb_reg_file_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;

  logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]      rd_busy_b, rd_busy_n;
  logic                iss_busy_b, iss_busy_n;
  logic [AW:0]         pend_b, pend_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_busy(iss_busy_b), .pend_cnt(pend_b)
  );

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_busy(iss_busy_n), .pend_cnt(pend_n)
  );

  // ---------------- reference model ----------------
  function automatic logic [AW:0] m_pend();
    int c = 0;
    for (int i = 0; i < NREG; i++) if (m_busy[i]) c++;
    return (AW+1)'(c);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(int a, bit byp);
    if (byp && wr_en && (wr_addr != 0) && (int'(wr_addr) == a)) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(int a, bit byp);
    if (byp && wr_en && (wr_addr != 0) && (int'(wr_addr) == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'h1234_5678;
    iss_en = 1'b1; iss_addr = 3;
    set_rd(5, 3);
    tick();
    tick();
    rst_n = 1'b1;
    wr_en = 1'b0; iss_en = 1'b0;
    #1;
    n_checks++; if (pend_b !== '0) begin n_errors++; $display("FAIL reset_pend: got %0d want 0", pend_b); end
    n_checks++; if (iss_busy_b !== 1'b0) begin n_errors++; $display("FAIL reset_iss_busy: got %b want 0", iss_busy_b); end
    n_checks++; if (rd_data_b !== '0) begin n_errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data_b); end
    n_checks++; if (rd_busy_b !== '0) begin n_errors++; $display("FAIL reset_rd_busy: got %b want 0", rd_busy_b); end
    n_checks++; if (rd_data_n !== '0 || pend_n !== '0) begin n_errors++; $display("FAIL reset_nobyp: got data %h pend %0d want 0", rd_data_n, pend_n); end
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEAD_BEEF;
    tick();
    idle();
    set_rd(5, 0);
    #1;
    n_checks++; if (rd_data_b[XLEN-1:0] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL wr_rd_x5: got %h want deadbeef", rd_data_b[XLEN-1:0]); end
    n_checks++; if (rd_data_n[XLEN-1:0] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL wr_rd_x5_nobyp: got %h want deadbeef", rd_data_n[XLEN-1:0]); end
    n_checks++; if (rd_busy_b[0] !== 1'b0) begin n_errors++; $display("FAIL wr_rd_x5_busy: got %b want 0", rd_busy_b[0]); end
    n_checks++; if (rd_data_b[XLEN +: XLEN] !== '0) begin n_errors++; $display("FAIL wr_rd_x0: got %h want 0", rd_data_b[XLEN +: XLEN]); end
  endtask

  task automatic test_issue();
    idle();
    iss_en = 1'b1; iss_addr = 7;
    tick();
    n_checks++; if (pend_b !== 6'd1) begin n_errors++; $display("FAIL issue_pend1: got %0d want 1", pend_b); end
    iss_addr = 9;
    tick();
    idle();
    set_rd(7, 9);
    #1;
    n_checks++; if (pend_b !== 6'd2) begin n_errors++; $display("FAIL issue_pend2: got %0d want 2", pend_b); end
    n_checks++; if (rd_busy_b !== 2'b11) begin n_errors++; $display("FAIL issue_rd_busy: got %b want 11", rd_busy_b); end
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h11;
    tick();
    idle();
    #1;
    n_checks++; if (pend_b !== 6'd1) begin n_errors++; $display("FAIL issue_wr_pend: got %0d want 1", pend_b); end
    n_checks++; if (rd_busy_b !== 2'b10) begin n_errors++; $display("FAIL issue_wr_busy: got %b want 10", rd_busy_b); end
    n_checks++; if (rd_data_b[XLEN-1:0] !== 32'h11) begin n_errors++; $display("FAIL issue_wr_data: got %h want 11", rd_data_b[XLEN-1:0]); end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] old;
    idle();
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h0000_0BEE;
    tick();
    idle();
    iss_en = 1'b1; iss_addr = 3;
    tick();
    idle();
    old = m_regs[3];
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h1234;
    set_rd(0, 3);
    #1;
    n_checks++; if (rd_data_b[XLEN +: XLEN] !== 32'h1234) begin n_errors++; $display("FAIL byp_data: got %h want 1234", rd_data_b[XLEN +: XLEN]); end
    n_checks++; if (rd_busy_b[1] !== 1'b0) begin n_errors++; $display("FAIL byp_busy: got %b want 0", rd_busy_b[1]); end
    n_checks++; if (rd_data_n[XLEN +: XLEN] !== old) begin n_errors++; $display("FAIL nobyp_data: got %h want %h", rd_data_n[XLEN +: XLEN], old); end
    n_checks++; if (rd_busy_n[1] !== 1'b1) begin n_errors++; $display("FAIL nobyp_busy: got %b want 1", rd_busy_n[1]); end
    tick();
    idle();
    #1;
    n_checks++; if (rd_data_n[XLEN +: XLEN] !== 32'h1234 || rd_busy_n[1] !== 1'b0) begin
      n_errors++; $display("FAIL nobyp_after: got %h/%b want 1234/0", rd_data_n[XLEN +: XLEN], rd_busy_n[1]);
    end
  endtask

  task automatic test_same_cycle();
    logic [AW:0] p;
    idle();
    iss_en = 1'b1; iss_addr = 4;
    tick();
    idle();
    p = m_pend();
    wr_en = 1'b1; wr_addr = 4; wr_data = 32'hA5A5_0004;
    iss_en = 1'b1; iss_addr = 4;
    #1;
    n_checks++; if (iss_busy_b !== 1'b1) begin n_errors++; $display("FAIL same_iss_busy: got %b want 1", iss_busy_b); end
    tick();
    idle();
    set_rd(4, 0);
    #1;
    n_checks++; if (rd_data_b[XLEN-1:0] !== 32'hA5A5_0004) begin n_errors++; $display("FAIL same_data: got %h want a5a50004", rd_data_b[XLEN-1:0]); end
    n_checks++; if (rd_busy_b[0] !== 1'b1) begin n_errors++; $display("FAIL same_busy: got %b want 1", rd_busy_b[0]); end
    n_checks++; if (pend_b !== p) begin n_errors++; $display("FAIL same_pend: got %0d want %0d", pend_b, p); end
    iss_en = 1'b1; iss_addr = 4;
    #1;
    n_checks++; if (iss_busy_b !== 1'b1 || iss_busy_n !== 1'b1) begin n_errors++; $display("FAIL reiss_busy: got %b/%b want 1/1", iss_busy_b, iss_busy_n); end
    tick();
    idle();
    #1;
    n_checks++; if (pend_b !== p) begin n_errors++; $display("FAIL reiss_pend: got %0d want %0d", pend_b, p); end
  endtask

  task automatic test_x0();
    logic [AW:0] p;
    idle();
    p = m_pend();
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_addr = 0;
    set_rd(0, 0);
    #1;
    n_checks++; if (rd_data_b !== '0) begin n_errors++; $display("FAIL x0_fwd: got %h want 0", rd_data_b); end
    n_checks++; if (iss_busy_b !== 1'b0) begin n_errors++; $display("FAIL x0_iss_busy: got %b want 0", iss_busy_b); end
    tick();
    idle();
    #1;
    n_checks++; if (rd_data_b !== '0 || rd_data_n !== '0) begin n_errors++; $display("FAIL x0_data: got %h/%h want 0", rd_data_b, rd_data_n); end
    n_checks++; if (rd_busy_b !== '0) begin n_errors++; $display("FAIL x0_busy: got %b want 0", rd_busy_b); end
    n_checks++; if (pend_b !== p) begin n_errors++; $display("FAIL x0_pend: got %0d want %0d", pend_b, p); end
  endtask

  task automatic test_reset_mid();
    idle();
    wr_en = 1'b1; wr_addr = 2; wr_data = 32'h55;
    tick();
    idle();
    iss_en = 1'b1; iss_addr = 2;
    tick();
    iss_addr = 6;
    tick();
    idle();
    set_rd(2, 6);
    #1;
    n_checks++; if (rd_busy_b !== 2'b11) begin n_errors++; $display("FAIL mid_pre_busy: got %b want 11", rd_busy_b); end
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 2; wr_data = 32'h99;
    iss_en = 1'b1; iss_addr = 10;
    tick();
    rst_n = 1'b1;
    idle();
    set_rd(2, 10);
    #1;
    n_checks++; if (pend_b !== '0 || pend_n !== '0) begin n_errors++; $display("FAIL mid_pend: got %0d/%0d want 0", pend_b, pend_n); end
    n_checks++; if (rd_data_b !== '0) begin n_errors++; $display("FAIL mid_data: got %h want 0", rd_data_b); end
    n_checks++; if (rd_busy_b !== '0) begin n_errors++; $display("FAIL mid_busy: got %b want 0", rd_busy_b); end
  endtask

  task automatic test_random();
    int a;
    logic [AW:0] ep;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_n    = ($urandom_range(0, 59) != 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NREG-1));
      wr_data  = $urandom;
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NREG-1));
      set_rd($urandom_range(0, 2) == 0 ? int'(wr_addr) : $urandom_range(0, 7),
             $urandom_range(0, 2) == 0 ? int'(wr_addr) : $urandom_range(0, NREG-1));
      #1;
      for (int p = 0; p < NRD; p++) begin
        a = int'(rd_addr[p*AW +: AW]);
        n_checks++; if (rd_data_b[p*XLEN +: XLEN] !== exp_data(a, 1'b1)) begin
          n_errors++; $display("FAIL rand_data_byp c%0d p%0d: got %h want %h", cyc, p, rd_data_b[p*XLEN +: XLEN], exp_data(a, 1'b1));
        end
        n_checks++; if (rd_data_n[p*XLEN +: XLEN] !== exp_data(a, 1'b0)) begin
          n_errors++; $display("FAIL rand_data_nob c%0d p%0d: got %h want %h", cyc, p, rd_data_n[p*XLEN +: XLEN], exp_data(a, 1'b0));
        end
        n_checks++; if (rd_busy_b[p] !== exp_busy(a, 1'b1) || rd_busy_n[p] !== exp_busy(a, 1'b0)) begin
          n_errors++; $display("FAIL rand_busy c%0d p%0d: got %b/%b want %b/%b", cyc, p, rd_busy_b[p], rd_busy_n[p], exp_busy(a, 1'b1), exp_busy(a, 1'b0));
        end
      end
      n_checks++; if (iss_busy_b !== m_busy[iss_addr] || iss_busy_n !== m_busy[iss_addr]) begin
        n_errors++; $display("FAIL rand_iss_busy c%0d: got %b/%b want %b", cyc, iss_busy_b, iss_busy_n, m_busy[iss_addr]);
      end
      ep = m_pend();
      n_checks++; if (pend_b !== ep || pend_n !== ep) begin
        n_errors++; $display("FAIL rand_pend c%0d: got %0d/%0d want %0d", cyc, pend_b, pend_n, ep);
      end
      tick();
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    rst_n = 1'b0;
    idle();
    set_rd(0, 0);
    test_reset();
    test_write_read();
    test_issue();
    test_bypass();
    test_same_cycle();
    test_x0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, register data width in bits; legal 8..64.
REQ-002 SHALL provide parameter NREG, default 32, number of architectural registers; power of two, legal 2..64; AW = $clog2(NREG).
REQ-003 SHALL provide parameter NRD, default 2, number of independent read ports; legal 1..4.
REQ-004 SHALL provide parameter BYPASS, default 1, where 1 enables same-cycle write-to-read forwarding.
REQ-005 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL provide port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL provide port rd_addr, input, NRD*AW, packed read addresses; port i is slice [i*AW +: AW].
REQ-008 SHALL provide port rd_data, output, NRD*XLEN, packed read data for each port.
REQ-009 SHALL provide port rd_busy, output, NRD, per-port pending-write flag for the addressed register.
REQ-010 SHALL provide port wr_en, input, 1, writeback strobe.
REQ-011 SHALL provide port wr_addr, input, AW, writeback destination.
REQ-012 SHALL provide port wr_data, input, XLEN, writeback data.
REQ-013 SHALL provide port iss_en, input, 1, issue strobe marking a destination as pending.
REQ-014 SHALL provide port iss_addr, input, AW, issued destination register.
REQ-015 SHALL provide port iss_busy, output, 1, combinational: iss_addr is already pending (WAW hazard indication).
REQ-016 SHALL provide port pend_cnt, output, AW+1, registered count of pending registers.

Function
REQ-017 Register 0 SHALL read as zero and never be busy; writes and issues to address 0 SHALL have no effect.
REQ-018 Reads SHALL be combinational: rd_data[i] = regs[rd_addr[i]]; zero latency.
REQ-019 With BYPASS=1, when wr_en=1 and wr_addr==rd_addr[i]!=0, rd_data[i] SHALL equal wr_data and rd_busy[i] SHALL be 0 in the same cycle.
REQ-020 With BYPASS=0, reads SHALL return the pre-edge register contents and busy bit; new data is visible the cycle after the write.
REQ-021 On a rising edge with rst_n=1 and wr_en=1, regs[wr_addr] SHALL take wr_data and busy[wr_addr] SHALL clear.
REQ-022 On a rising edge with rst_n=1 and iss_en=1, busy[iss_addr] SHALL set.
REQ-023 Issue and write to the same nonzero address in one cycle: data SHALL be written and busy SHALL end set (issue wins).
REQ-024 Issue to an already-busy register SHALL be accepted, busy stays 1, pend_cnt unchanged; iss_busy=1 that cycle.
REQ-025 Write to a non-busy register SHALL update data only; busy and pend_cnt unchanged.
REQ-026 rd_busy[i] SHALL equal busy[rd_addr[i]] except as masked by REQ-019; iss_busy SHALL equal busy[iss_addr] (0 for address 0).
REQ-027 pend_cnt SHALL always equal popcount(busy) after each edge: +1 on an issue setting a clear bit, -1 on a write clearing a set bit not re-issued, both applied in one cycle when they target different registers.
REQ-028 pend_cnt SHALL never exceed NREG-1 nor underflow; no saturation logic is required beyond REQ-027 consistency.
REQ-029 Any number of read ports SHALL be able to address the same register simultaneously with identical results.

Reset
REQ-030 On a rising edge with rst_n=0, all registers SHALL clear to 0, all busy bits clear, pend_cnt=0.
REQ-031 wr_en and iss_en SHALL be ignored on any edge where rst_n=0, including reset asserted mid-sequence with pending registers.
REQ-032 Outputs SHALL be rd_data=0, rd_busy=0, iss_busy=0, pend_cnt=0 from the first edge after reset.

Verification
REQ-033 Reset then write x5=0xDEADBEEF, next cycle read port0 addr 5 -> rd_data=0xDEADBEEF, rd_busy=0; read addr 0 -> 0.
REQ-034 Issue x7, then x9 -> pend_cnt 1 then 2, rd_busy for 7 and 9 = 1; write x7=0x11 -> pend_cnt=1, x7 not busy.
REQ-035 BYPASS=1: write x3=0x1234 while port1 reads x3 -> same-cycle rd_data=0x1234, rd_busy=0; BYPASS=0 -> old value, busy per state.
REQ-036 Same-cycle issue and write to x4 (busy) -> x4 data updated, busy stays 1, pend_cnt unchanged; issue x4 again -> iss_busy=1, pend_cnt unchanged.
REQ-037 Write x0=0xFFFFFFFF and issue x0 -> x0 reads 0, not busy, pend_cnt unchanged.
REQ-038 With x2,x6 pending and x2=0x55, assert rst_n=0 one cycle with wr_en=1 -> all regs 0, pend_cnt=0, no write.
